// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - snooping bus controller arbitrating CPU fetches, writebacks and
// coherence misses onto a single RAM port, with cache-to-cache transfer on snoop hits.
module coherence_bus_ctrl #(
    parameter int NCPU = 2,
    parameter int BLKW = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NCPU-1:0]        iREN,
    input  logic [NCPU-1:0][31:0]  iaddr,
    output logic [NCPU-1:0]        iwait,
    output logic [NCPU-1:0][31:0]  iload,
    input  logic [NCPU-1:0]        dREN,
    input  logic [NCPU-1:0]        dWEN,
    input  logic [NCPU-1:0][31:0]  daddr,
    input  logic [NCPU-1:0][31:0]  dstore,
    output logic [NCPU-1:0]        dwait,
    output logic [NCPU-1:0][31:0]  dload,
    input  logic [NCPU-1:0]        cctrans,
    input  logic [NCPU-1:0]        ccwrite,
    output logic [NCPU-1:0]        ccwait,
    output logic [NCPU-1:0]        ccinv,
    output logic [NCPU-1:0][31:0]  ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate
);
    localparam int IW = $clog2(NCPU);
    localparam int CW = (BLKW > 1) ? $clog2(BLKW) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {IDLE, SNOOP, C2C, RAMRD, WB, IFETCH} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   req_q, req_d, sup_q, sup_d;
    logic [IW-1:0]   wb_ptr_q, wb_ptr_d, coh_ptr_q, coh_ptr_d, ins_ptr_q, ins_ptr_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [NCPU-1:0] wb_req;
    logic            access, last_beat, snoop_hit;
    logic [IW-1:0]   snoop_sup;

    // Round-robin search starting at the pointer; the lowest offset wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NCPU-1:0] m, input logic [IW-1:0] p);
        logic [IW-1:0] r;
        int j;
        r = p;
        for (int i = NCPU - 1; i >= 0; i--) begin
            j = (int'(p) + i) % NCPU;
            if (m[j]) r = IW'(j);
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] w);
        return (w == IW'(NCPU - 1)) ? '0 : w + IW'(1);
    endfunction

    assign wb_req    = dWEN & ~cctrans;
    assign access    = (ramstate == RAM_ACCESS);
    assign last_beat = (wcnt_q == CW'(BLKW - 1));

    always_comb begin
        snoop_hit = 1'b0;
        snoop_sup = '0;
        for (int k = NCPU - 1; k >= 0; k--) begin
            if (k != int'(req_q) && ccwrite[k]) begin
                snoop_hit = 1'b1;
                snoop_sup = IW'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        sup_d       = sup_q;
        wcnt_d      = wcnt_q;
        wb_ptr_d    = wb_ptr_q;
        coh_ptr_d   = coh_ptr_q;
        ins_ptr_d   = ins_ptr_q;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        dload       = '0;
        iload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (|wb_req) begin
                    req_d   = rr_pick(wb_req, wb_ptr_q);
                    state_d = WB;
                end else if (|cctrans) begin
                    req_d   = rr_pick(cctrans, coh_ptr_q);
                    state_d = SNOOP;
                end else if (|iREN) begin
                    req_d   = rr_pick(iREN, ins_ptr_q);
                    state_d = IFETCH;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[req_q];
                ramstore = dstore[req_q];
                if (access) begin
                    dwait[req_q] = 1'b0;
                    wcnt_d       = wcnt_q + CW'(1);
                    if (last_beat) begin
                        state_d  = IDLE;
                        wb_ptr_d = rr_next(req_q);
                    end
                end
            end
            SNOOP: begin
                for (int k = 0; k < NCPU; k++) begin
                    if (k != int'(req_q)) begin
                        ccwait[k]      = 1'b1;
                        ccsnoopaddr[k] = daddr[req_q];
                        ccinv[k]       = ccwrite[req_q];
                    end
                end
                if (snoop_hit) begin
                    sup_d   = snoop_sup;
                    state_d = C2C;
                end else if (dREN[req_q]) begin
                    state_d = RAMRD;
                end else begin
                    // Upgrade with no data needed: invalidation alone completes it.
                    dwait[req_q] = 1'b0;
                    state_d      = IDLE;
                    coh_ptr_d    = rr_next(req_q);
                end
            end
            C2C, RAMRD: begin
                for (int k = 0; k < NCPU; k++) begin
                    if (k != int'(req_q)) ccwait[k] = 1'b1;
                end
                if (state_q == C2C) begin
                    ramWEN       = 1'b1;
                    ramaddr      = daddr[sup_q];
                    ramstore     = dstore[sup_q];
                    dload[req_q] = dstore[sup_q];
                end else begin
                    ramREN       = 1'b1;
                    ramaddr      = daddr[req_q];
                    dload[req_q] = ramload;
                end
                if (access) begin
                    dwait[req_q] = 1'b0;
                    if (state_q == C2C) dwait[sup_q] = 1'b0;
                    wcnt_d = wcnt_q + CW'(1);
                    if (last_beat) begin
                        state_d   = IDLE;
                        coh_ptr_d = rr_next(req_q);
                    end
                end
            end
            IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[req_q];
                iload[req_q] = ramload;
                if (access) begin
                    iwait[req_q] = 1'b0;
                    state_d      = IDLE;
                    ins_ptr_d    = rr_next(req_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            req_q     <= '0;
            sup_q     <= '0;
            wcnt_q    <= '0;
            wb_ptr_q  <= '0;
            coh_ptr_q <= '0;
            ins_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            sup_q     <= sup_d;
            wcnt_q    <= wcnt_d;
            wb_ptr_q  <= wb_ptr_d;
            coh_ptr_q <= coh_ptr_d;
            ins_ptr_q <= ins_ptr_d;
        end
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - directed self-checking bench for coherence_bus_ctrl (NCPU=4, BLKW=2).
module tb_coherence_bus_ctrl;
    localparam logic [1:0] FREE = 2'd0, ACCESS = 2'd2, ERROR = 2'd3;

    logic             CLK, nRST;
    logic [3:0]       iREN, iwait, dREN, dWEN, dwait;
    logic [3:0]       cctrans, ccwrite, ccwait, ccinv;
    logic [3:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;
    int               tests, fails;

    coherence_bus_ctrl #(.NCPU(4), .BLKW(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        chk({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        chk({tag, "_dwait"}, 32'(dwait), 32'hF);
        chk({tag, "_iwait"}, 32'(iwait), 32'hF);
        chk({tag, "_ccwait"}, 32'(ccwait), 32'h0);
    endtask

    initial begin
        tests = 0; fails = 0;
        nRST = 1'b0; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        cctrans = '0; ccwrite = '0; ramload = '0; ramstate = FREE;
        #3;
        chk_idle("reset");
        chk("reset_ramaddr", ramaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Two fetchers, ACCESS on alternate cycles: grants must alternate 0,1,0,1.
        iREN = 4'b0011; iaddr[0] = 32'h1000; iaddr[1] = 32'h2000; ramload = 32'hCAFE0000;
        for (int i = 0; i < 4; i++) begin
            step();
            ramstate = ACCESS;
            #1;
            chk($sformatf("fetch%0d_ramaddr", i), ramaddr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
            chk($sformatf("fetch%0d_ramREN", i), 32'(ramREN), 32'd1);
            chk($sformatf("fetch%0d_iwait", i), 32'(iwait), (i % 2 == 0) ? 32'hE : 32'hD);
            chk($sformatf("fetch%0d_iload", i), iload[i % 2], 32'hCAFE0000);
            step();
            ramstate = FREE;
            if (i == 3) iREN = '0;
            #1;
            chk($sformatf("fetch%0d_idle_iwait", i), 32'(iwait), 32'hF);
        end

        // Writeback from cache 1 beats a simultaneous fetch from CPU 0.
        dWEN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'h11; iREN[0] = 1'b1; iaddr[0] = 32'h4000;
        step();
        #1;
        chk("wb_ramWEN", 32'(ramWEN), 32'd1);
        chk("wb_ramREN", 32'(ramREN), 32'd0);
        chk("wb_ramaddr", ramaddr, 32'h100);
        chk("wb_ramstore", ramstore, 32'h11);
        chk("wb_hold_dwait", 32'(dwait), 32'hF);
        ramstate = ACCESS;
        #1;
        chk("wb_beat1_dwait", 32'(dwait), 32'hD);
        step();
        dWEN = '0;
        #1;
        chk("wb_beat2_dwait", 32'(dwait), 32'hD);
        chk("wb_beat2_ramWEN", 32'(ramWEN), 32'd1);
        step();
        #1;
        chk_idle("wb_done");
        step();
        ramload = 32'h0000BEEF;
        #1;
        chk("wbf_ramREN", 32'(ramREN), 32'd1);
        chk("wbf_ramaddr", ramaddr, 32'h4000);
        chk("wbf_iload", iload[0], 32'h0000BEEF);
        chk("wbf_iwait", 32'(iwait), 32'hE);
        iREN = '0;
        step();
        ramstate = FREE;
        #1;
        chk_idle("wbf_done");

        // Cache 2 misses, cache 3 holds the line modified: cache-to-cache transfer.
        cctrans[2] = 1'b1; dREN[2] = 1'b1; daddr[2] = 32'h200; daddr[3] = 32'h300;
        dstore[3] = 32'hDEAD0003;
        step();
        ccwrite[3] = 1'b1;
        #1;
        chk("c2c_snoop_ccwait", 32'(ccwait), 32'hB);
        chk("c2c_snoop_addr", ccsnoopaddr[3], 32'h200);
        chk("c2c_snoop_ccinv", 32'(ccinv), 32'h0);
        chk("c2c_snoop_ram", {30'd0, ramREN, ramWEN}, 32'd0);
        step();
        cctrans = '0; dREN = '0; ccwrite = '0;
        #1;
        chk("c2c_ramWEN", 32'(ramWEN), 32'd1);
        chk("c2c_ramaddr", ramaddr, 32'h300);
        chk("c2c_ramstore", ramstore, 32'hDEAD0003);
        chk("c2c_dload", dload[2], 32'hDEAD0003);
        chk("c2c_hold_dwait", 32'(dwait), 32'hF);
        ramstate = ACCESS;
        #1;
        chk("c2c_beat1_dwait", 32'(dwait), 32'h3);
        step();
        #1;
        chk("c2c_beat2_dwait", 32'(dwait), 32'h3);
        chk("c2c_beat2_ccwait", 32'(ccwait), 32'hB);
        step();
        ramstate = FREE;
        #1;
        chk_idle("c2c_done");

        // Invalidate-only upgrade from cache 0: one dwait pulse, no RAM traffic.
        cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h80;
        step();
        cctrans = '0;
        #1;
        chk("upg_ccinv", 32'(ccinv), 32'hE);
        chk("upg_ccwait", 32'(ccwait), 32'hE);
        chk("upg_snoopaddr", ccsnoopaddr[1], 32'h80);
        chk("upg_dwait", 32'(dwait), 32'hE);
        chk("upg_ram", {30'd0, ramREN, ramWEN}, 32'd0);
        ccwrite = '0;
        step();
        #1;
        chk_idle("upg_done");

        // RAM read for cache 1 with ERROR held for 5 cycles: no progress, then 2 beats.
        cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h140; ramload = 32'h5555;
        step();
        cctrans = '0;
        step();
        dREN = '0; ramstate = ERROR;
        #1;
        chk("rd_ramREN", 32'(ramREN), 32'd1);
        chk("rd_ramaddr", ramaddr, 32'h140);
        chk("rd_dload", dload[1], 32'h5555);
        chk("rd_ccwait", 32'(ccwait), 32'hD);
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk($sformatf("rd_err%0d_dwait", i), 32'(dwait), 32'hF);
            chk($sformatf("rd_err%0d_ramREN", i), 32'(ramREN), 32'd1);
        end
        ramstate = ACCESS;
        #1;
        chk("rd_beat1_dwait", 32'(dwait), 32'hD);
        step();
        #1;
        chk("rd_beat2_dwait", 32'(dwait), 32'hD);
        chk("rd_beat2_ramREN", 32'(ramREN), 32'd1);
        step();
        ramstate = FREE;
        #1;
        chk_idle("rd_done");

        // Reset during the first C2C beat aborts it immediately.
        cctrans[2] = 1'b1; dREN[2] = 1'b1;
        step();
        ccwrite[3] = 1'b1; cctrans = '0;
        step();
        dREN = '0; ccwrite = '0; ramstate = ACCESS;
        #1;
        chk("rst_c2c_dwait", 32'(dwait), 32'h3);
        nRST = 1'b0;
        #1;
        chk_idle("rst_async");
        step();
        #1;
        chk_idle("rst_held");
        nRST = 1'b1;
        step();
        #1;
        chk_idle("rst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
